// File: rtl/param_shift_engine.sv
// rtl/param_shift_engine.sv - multi-cycle universal shift register, one bit position per clock
// Optional serial fill/tap ports: define PARAM_SHIFT_SERIAL_IO_EN.
module param_shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
`ifdef PARAM_SHIFT_SERIAL_IO_EN
    input  logic             serial_in,
    output logic             serial_out,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic             dir_r;
    logic [1:0]       mode_r;
    logic             log_fill;
    logic             fill;
    logic [WIDTH-1:0] q_shift;

`ifdef PARAM_SHIFT_SERIAL_IO_EN
    assign log_fill   = serial_in;
    assign serial_out = ((state == SHIFT) ? dir_r : dir) ? q[WIDTH-1] : q[0];
`else
    assign log_fill   = 1'b0;
`endif

    // Fill bit for the one-position step; mode 11 falls through to logical.
    always_comb begin
        fill = log_fill;
        case (mode_r)
            2'b01:   fill = dir_r ? 1'b0 : q[WIDTH-1];
            2'b10:   fill = dir_r ? q[WIDTH-1] : q[0];
            default: fill = log_fill;
        endcase
        q_shift = dir_r ? {q[WIDTH-2:0], fill} : {fill, q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            dir_r  <= 1'b0;
            mode_r <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        q <= load_val;
                    end else if (start) begin
                        dir_r  <= dir;
                        mode_r <= mode;
                        cnt    <= amount;
                        if (amount != '0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    q   <= q_shift;
                    cnt <= cnt - 1'b1;
                    if (cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_shift_engine.sv
// tb/tb_param_shift_engine.sv - self-checking bench for param_shift_engine
module tb_param_shift_engine;
    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset, load, start, dir;
    logic [W-1:0] load_val;
    logic [1:0]   mode;
    logic [A-1:0] amount;
    logic [W-1:0] q;
    logic         busy, done;
`ifdef PARAM_SHIFT_SERIAL_IO_EN
    logic         serial_in = 1'b0;
    logic         serial_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    param_shift_engine #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .dir(dir), .mode(mode), .amount(amount),
`ifdef PARAM_SHIFT_SERIAL_IO_EN
        .serial_in(serial_in), .serial_out(serial_out),
`endif
        .q(q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic [W-1:0] val;
        logic         d;
        logic [1:0]   m;
        logic [A-1:0] n;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-command result from plain shift arithmetic.
    function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic d,
                                           input logic [1:0] m, input int n);
        logic signed [W-1:0] sv;
        logic [2*W-1:0]      dbl;
        int r;
        if (m == 2'b10) begin
            r   = n % W;
            dbl = {v, v};
            if (d) return dbl[2*W-1-r -: W];
            else   return dbl[r +: W];
        end
        if (m == 2'b01 && !d) begin
            sv = v;
            return sv >>> n;
        end
        if (n >= W) return '0;
        return d ? (v << n) : (v >> n);
    endfunction

    // Load, start a command, wait (bounded) for done, check latency/result/handshake.
    task automatic do_cmd(input string nm, input logic [W-1:0] v, input logic d,
                          input logic [1:0] m, input logic [A-1:0] n,
                          input logic [W-1:0] exp, input bit poke);
        int c;
        bit busy_ok;
        load = 1'b1; load_val = v; start = 1'b0;
        tick();
        load = 1'b0;
        start = 1'b1; dir = d; mode = m; amount = n;
        tick();
        start = 1'b0; dir = ~d; mode = ~m; amount = ~n;
        c = 0;
        busy_ok = 1'b1;
        while (!done && c < 40) begin
            if (!busy) busy_ok = 1'b0;
            load = poke ? c[0] : 1'b0;
            load_val = ~v;
            tick();
            c++;
        end
        load = 1'b0;
        chk({nm, "_latency"}, c, n);
        chk({nm, "_busy_during"}, busy_ok, 1);
        chk({nm, "_q"}, q, exp);
        chk({nm, "_done_busy_excl"}, busy, 0);
        tick();
        chk({nm, "_done_width"}, done, 0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; dir = 1'b0;
        mode = 2'b00; amount = '0; load_val = '0;
        tbl[0]  = '{"asr_96_3",  8'h96, 1'b0, 2'b01, 4'd3,  8'hF2};
        tbl[1]  = '{"rol_81_9",  8'h81, 1'b1, 2'b10, 4'd9,  8'h03};
        tbl[2]  = '{"zero_3c",   8'h3C, 1'b0, 2'b00, 4'd0,  8'h3C};
        tbl[3]  = '{"lsr_f0_6",  8'hF0, 1'b0, 2'b00, 4'd6,  8'h03};
        tbl[4]  = '{"lsl_0f_4",  8'h0F, 1'b1, 2'b00, 4'd4,  8'hF0};
        tbl[5]  = '{"asl_81_1",  8'h81, 1'b1, 2'b01, 4'd1,  8'h02};
        tbl[6]  = '{"ror_01_1",  8'h01, 1'b0, 2'b10, 4'd1,  8'h80};
        tbl[7]  = '{"m3r_80_15", 8'h80, 1'b0, 2'b11, 4'd15, 8'h00};
        tbl[8]  = '{"asr_80_15", 8'h80, 1'b0, 2'b01, 4'd15, 8'hFF};
        tbl[9]  = '{"ror_a5_8",  8'hA5, 1'b0, 2'b10, 4'd8,  8'hA5};
        tbl[10] = '{"lsl_ff_8",  8'hFF, 1'b1, 2'b00, 4'd8,  8'h00};

        tick(); tick();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // Reset two cycles after a load.
        load = 1'b1; load_val = 8'hFF; tick(); load = 1'b0;
        chk("load_ff", q, 8'hFF);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_after_load_q", q, 0);
        chk("rst_after_load_busy", busy, 0);
        chk("rst_after_load_done", done, 0);

        // Load beats a simultaneous start.
        load = 1'b1; start = 1'b1; load_val = 8'hA5; dir = 1'b0; mode = 2'b00; amount = 4'd3;
        tick();
        load = 1'b0; start = 1'b0;
        chk("prio_q", q, 8'hA5);
        chk("prio_busy", busy, 0);
        tick();
        chk("prio_busy2", busy, 0);
        chk("prio_done", done, 0);
        chk("prio_q2", q, 8'hA5);

        // Arithmetic right, step by step.
        load = 1'b1; load_val = 8'h96; tick(); load = 1'b0;
        start = 1'b1; dir = 1'b0; mode = 2'b01; amount = 4'd3; tick(); start = 1'b0;
        chk("asr_k_busy", busy, 1);
        chk("asr_k_q", q, 8'h96);
        tick(); chk("asr_1_q", q, 8'hCB); chk("asr_1_busy", busy, 1);
        tick(); chk("asr_2_q", q, 8'hE5); chk("asr_2_busy", busy, 1);
        tick(); chk("asr_3_q", q, 8'hF2); chk("asr_3_busy", busy, 0); chk("asr_3_done", done, 1);
        tick(); chk("asr_after_done", done, 0);

        // Directed table.
        for (int i = 0; i < 11; i++)
            do_cmd(tbl[i].nm, tbl[i].val, tbl[i].d, tbl[i].m, tbl[i].n, tbl[i].exp, 1'b0);

        // Rotate-left wrap with load pulses while busy.
        do_cmd("rol_poke", 8'h81, 1'b1, 2'b10, 4'd9, 8'h03, 1'b1);

        // Reset mid-command.
        load = 1'b1; load_val = 8'hF0; tick(); load = 1'b0;
        start = 1'b1; dir = 1'b0; mode = 2'b00; amount = 4'd6; tick(); start = 1'b0;
        tick(); chk("mid_1_q", q, 8'h78);
        tick(); chk("mid_2_q", q, 8'h3C);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_busy", busy, 0);
        begin
            bit quiet = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (done || busy || q != 0) quiet = 1'b0;
                tick();
            end
            chk("mid_rst_no_done", quiet, 1);
        end

        // Randomised commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] v;
            logic         d;
            logic [1:0]   m;
            logic [A-1:0] n;
            v = W'($urandom);
            d = 1'($urandom);
            m = 2'($urandom);
            n = A'($urandom);
            do_cmd($sformatf("rnd%0d", i), v, d, m, n, model(v, d, m, int'(n)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
